// File: rtl/uart_mem_xfer.sv
// UART-to-memory loader and memory-to-UART dumper; width, depth, read latency and byte order are parameters.
// Define UART_MEM_CHKSUM_EN to add a trailing modulo-256 checksum byte and the chk_err port.
module uart_mem_xfer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 256,
    parameter int RD_LAT     = 1,
    parameter int MSB_FIRST  = 1,
    parameter int RX_TIMEOUT = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_load,
    input  logic                   start_dump,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [$clog2(DEPTH):0] word_count,
    input  logic                   rx_dv,
    input  logic [7:0]             rx_byte,
    output logic                   tx_dv,
    output logic [7:0]             tx_byte,
    input  logic                   tx_active,
    input  logic                   tx_done,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_we,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   busy,
    output logic                   load_done,
    output logic                   dump_done,
`ifdef UART_MEM_CHKSUM_EN
    output logic                   err_timeout,
    output logic                   chk_err
`else
    output logic                   err_timeout
`endif
);
    localparam int NB     = DATA_W / 8;
    localparam int BC_W   = (NB > 1) ? $clog2(NB) : 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int TO_W   = $clog2(RX_TIMEOUT + 1);
    localparam int STAGES = RD_LAT - 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, LOAD_WR, DUMP_RD, DUMP_WAIT, DUMP_TX, DUMP_ACK
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt, idx;
    logic [BC_W-1:0]   bcnt;
    logic [TO_W-1:0]   tcnt;
    logic [DATA_W-1:0] wbuf, sbuf;
    logic [STAGES:0]   vld_pipe;
`ifdef UART_MEM_CHKSUM_EN
    logic [7:0]        csum;
    logic              chk_phase;
`endif

    logic [CNT_W-1:0]  eff_cnt, idx_nxt;
    logic [DATA_W-1:0] rx_ext, word_nxt;
    logic [7:0]        tx_sel;
    logic              last_byte, load_end;

    assign eff_cnt   = (word_count == '0 || word_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : word_count;
    // idx is bumped during LOAD_WR, so decisions taken in that cycle look one word ahead
    assign idx_nxt   = (state == LOAD_WR) ? idx + CNT_W'(1) : idx;
    assign load_end  = (idx_nxt == cnt);
    assign last_byte = (bcnt == BC_W'(NB - 1));
    assign rx_ext    = DATA_W'(rx_byte);
    assign word_nxt  = (MSB_FIRST != 0) ? ((wbuf << 8) | rx_ext)
                                        : ((wbuf >> 8) | (rx_ext << (DATA_W - 8)));
    assign tx_sel    = (MSB_FIRST != 0) ? sbuf[DATA_W-1 -: 8] : sbuf[7:0];

`ifdef UART_MEM_CHKSUM_EN
    function automatic logic [7:0] byte_sum(input logic [DATA_W-1:0] w);
        logic [7:0] s;
        s = '0;
        for (int k = 0; k < NB; k++) s = s + w[8*k +: 8];
        return s;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            bcnt        <= '0;
            tcnt        <= '0;
            wbuf        <= '0;
            sbuf        <= '0;
            vld_pipe    <= '0;
            tx_dv       <= 1'b0;
            tx_byte     <= '0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            load_done   <= 1'b0;
            dump_done   <= 1'b0;
            err_timeout <= 1'b0;
`ifdef UART_MEM_CHKSUM_EN
            csum        <= '0;
            chk_phase   <= 1'b0;
            chk_err     <= 1'b0;
`endif
        end else begin
            mem_we   <= 1'b0;
            tx_dv    <= 1'b0;
            vld_pipe <= vld_pipe << 1;
            case (state)
                IDLE: begin
                    if (start_load || start_dump) begin
                        load_done   <= 1'b0;
                        dump_done   <= 1'b0;
                        err_timeout <= 1'b0;
                        mem_addr    <= base_addr;
                        cnt         <= eff_cnt;
                        idx         <= '0;
                        bcnt        <= '0;
                        tcnt        <= '0;
                        busy        <= 1'b1;
`ifdef UART_MEM_CHKSUM_EN
                        csum        <= '0;
                        chk_phase   <= 1'b0;
                        chk_err     <= 1'b0;
`endif
                        state       <= start_load ? LOAD : DUMP_RD;
                    end
                end
                LOAD, LOAD_WR: begin
                    if (state == LOAD_WR) begin
                        idx      <= idx_nxt;
                        mem_addr <= mem_addr + ADDR_W'(NB);
                    end
                    if (rx_dv && !load_end) begin
                        tcnt <= '0;
                        wbuf <= word_nxt;
                        if (last_byte) begin
                            bcnt      <= '0;
                            mem_wdata <= word_nxt;
                            mem_we    <= 1'b1;
                            state     <= LOAD_WR;
`ifdef UART_MEM_CHKSUM_EN
                            csum      <= csum + byte_sum(word_nxt);
`endif
                        end else begin
                            bcnt  <= bcnt + BC_W'(1);
                            state <= LOAD;
                        end
                    end
`ifdef UART_MEM_CHKSUM_EN
                    else if (rx_dv) begin
                        chk_err   <= (rx_byte != csum);
                        load_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
`else
                    else if (load_end) begin
                        load_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
`endif
                    else if (state == LOAD_WR) begin
                        state <= LOAD;
                    end else if (bcnt != '0) begin
                        // stalled mid-word: drop the partial word but keep the load running
                        if (tcnt == TO_W'(RX_TIMEOUT - 1)) begin
                            bcnt        <= '0;
                            tcnt        <= '0;
                            err_timeout <= 1'b1;
                        end else begin
                            tcnt <= tcnt + TO_W'(1);
                        end
                    end
                end
                DUMP_RD: begin
                    vld_pipe <= (STAGES + 1)'(1);
                    state    <= DUMP_WAIT;
                end
                DUMP_WAIT: begin
                    if (vld_pipe[STAGES]) begin
                        sbuf  <= mem_rdata;
                        bcnt  <= '0;
                        state <= DUMP_TX;
                    end
                end
                DUMP_TX: begin
                    if (!tx_active) begin
                        tx_dv <= 1'b1;
                        sbuf  <= (MSB_FIRST != 0) ? (sbuf << 8) : (sbuf >> 8);
                        state <= DUMP_ACK;
`ifdef UART_MEM_CHKSUM_EN
                        if (chk_phase) begin
                            tx_byte <= csum;
                        end else begin
                            tx_byte <= tx_sel;
                            csum    <= csum + tx_sel;
                        end
`else
                        tx_byte <= tx_sel;
`endif
                    end
                end
                DUMP_ACK: begin
                    if (tx_done) begin
`ifdef UART_MEM_CHKSUM_EN
                        if (chk_phase) begin
                            dump_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else
`endif
                        if (last_byte) begin
                            if (idx + CNT_W'(1) == cnt) begin
`ifdef UART_MEM_CHKSUM_EN
                                chk_phase <= 1'b1;
                                state     <= DUMP_TX;
`else
                                dump_done <= 1'b1;
                                busy      <= 1'b0;
                                state     <= IDLE;
`endif
                            end else begin
                                idx      <= idx + CNT_W'(1);
                                mem_addr <= mem_addr + ADDR_W'(NB);
                                bcnt     <= '0;
                                state    <= DUMP_RD;
                            end
                        end else begin
                            bcnt  <= bcnt + BC_W'(1);
                            state <= DUMP_TX;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mem_xfer.sv
// Randomized self-checking bench for uart_mem_xfer with a memory model, a uart_tx model and a
// transfer-level reference (expected writes / byte stream computed from byte lists).
module tb_uart_mem_xfer;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int DEP = 4;
    localparam int RL  = 2;
    localparam int MSB = 1;
    localparam int RXT = 24;
    localparam int NB  = DW / 8;
    localparam int CW  = $clog2(DEP) + 1;
    localparam int TXC = 5;

    typedef logic [7:0] bq_t [$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_load = 1'b0, start_dump = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] word_count = '0;
    logic          rx_dv = 1'b0;
    logic [7:0]    rx_byte = '0;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          tx_active = 1'b0, tx_done = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy, load_done, dump_done, err_timeout;
`ifdef UART_MEM_CHKSUM_EN
    logic          chk_err;
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    uart_mem_xfer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(RL),
                    .MSB_FIRST(MSB), .RX_TIMEOUT(RXT)) dut (
        .clk(clk), .rst(rst), .start_load(start_load), .start_dump(start_dump),
        .base_addr(base_addr), .word_count(word_count), .rx_dv(rx_dv), .rx_byte(rx_byte),
        .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_active(tx_active), .tx_done(tx_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .load_done(load_done), .dump_done(dump_done),
`ifdef UART_MEM_CHKSUM_EN
        .err_timeout(err_timeout), .chk_err(chk_err)
`else
        .err_timeout(err_timeout)
`endif
    );

    // memory model with RL-cycle read latency
    logic [DW-1:0] mem_m [logic [AW-1:0]];
    logic [DW-1:0] rdp [RL];
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    always @(posedge clk) begin
        rdp[0] <= mem_m.exists(mem_addr) ? mem_m[mem_addr] : '0;
        for (int i = 1; i < RL; i++) rdp[i] <= rdp[i-1];
    end
    assign mem_rdata = rdp[RL-1];

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            mem_m[mem_addr] = mem_wdata;
        end
    end

    // uart_tx model: busy for TXC cycles after each tx_dv, then a one-cycle tx_done
    logic [7:0] tx_q [$];
    int tx_cnt = 0, tx_viol = 0;
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (rst) begin
            tx_active = 1'b0;
            tx_cnt = 0;
        end else begin
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_active = 1'b0;
                    tx_done = 1'b1;
                end
            end
            if (tx_dv) begin
                if (tx_active) tx_viol++;
                tx_q.push_back(tx_byte);
                tx_active = 1'b1;
                tx_cnt = TXC;
            end
        end
    end

    function automatic int eff(input int wc);
        return (wc == 0 || wc > DEP) ? DEP : wc;
    endfunction

    function automatic logic [DW-1:0] pack_word(input bq_t b, input int w);
        logic [DW-1:0] r = '0;
        for (int k = 0; k < NB; k++)
            if (MSB != 0) r = (r << 8) | DW'(b[w*NB+k]);
            else          r = r | (DW'(b[w*NB+k]) << (8*k));
        return r;
    endfunction

    function automatic logic [7:0] word_byte(input logic [DW-1:0] w, input int k);
        int sh = (MSB != 0) ? 8*(NB-1-k) : 8*k;
        return w[sh +: 8];
    endfunction

    function automatic logic [7:0] sum_bytes(input bq_t b);
        logic [7:0] s = '0;
        foreach (b[i]) s = s + b[i];
        return s;
    endfunction

    task automatic do_start(input bit l, input bit d, input logic [AW-1:0] base, input int wc);
        @(negedge clk);
        start_load = l; start_dump = d; base_addr = base; word_count = CW'(wc);
        @(negedge clk);
        start_load = 1'b0; start_dump = 1'b0;
    endtask

    // called at a negedge; returns at a negedge
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte = b; rx_dv = 1'b1;
        @(negedge clk);
        rx_dv = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_done(input bit dump, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (dump ? dump_done : load_done) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, load_done, dump_done, err_timeout, mem_we, tx_dv} !== 6'b0 || mem_addr !== '0
            || mem_wdata !== '0 || tx_byte !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b ld=%b dd=%b to=%b we=%b txdv=%b addr=%h",
                     busy, load_done, dump_done, err_timeout, mem_we, tx_dv, mem_addr);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b we=%b required 0 0", busy, mem_we);
        end
    endtask

    task automatic test_load;
        bq_t b;
        logic [AW-1:0] base;
        int wc, n, gap;
        for (int it = 0; it < 6; it++) begin
            b.delete();
            if (it == 0) begin
                base = 32'h100; wc = 2;
                b = {8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
            end else if (it == 1) begin
                base = 32'hFFFF_FFF8; wc = 3;   // address wraps to 0
                for (int i = 0; i < 3*NB; i++) b.push_back(8'($urandom));
            end else begin
                base = $urandom; wc = $urandom_range(0, 7);
                for (int i = 0; i < eff(wc)*NB; i++) b.push_back(8'($urandom));
            end
            n = eff(wc);
            wr_addr_q.delete(); wr_data_q.delete();
            do_start(1'b1, 1'b0, base, wc);
            foreach (b[j]) begin
                gap = (it == 0) ? 0 : $urandom_range(0, 3);
                send_byte(b[j], gap);
                if (it == 0 && j == NB-1) begin
                    checks++;
                    if (mem_we !== 1'b1 || mem_addr !== base) begin
                        failures++;
                        $display("FAIL load_write_timing got we=%b addr=%h required 1 %h", mem_we, mem_addr, base);
                    end
                end
            end
            if (CHK != 0) send_byte(sum_bytes(b), 0);
            wait_done(1'b0, 500);
            checks++;
            if (load_done !== 1'b1 || busy !== 1'b0 || err_timeout !== 1'b0 || dump_done !== 1'b0) begin
                failures++;
                $display("FAIL load_status it=%0d got ld=%b busy=%b to=%b dd=%b required 1 0 0 0",
                         it, load_done, busy, err_timeout, dump_done);
            end
            checks++;
            if (wr_addr_q.size() != n) begin
                failures++;
                $display("FAIL load_count it=%0d got %0d writes required %0d", it, wr_addr_q.size(), n);
            end else begin
                for (int w = 0; w < n; w++) begin
                    logic [AW-1:0] ea = base + AW'(w*NB);
                    checks++;
                    if (wr_addr_q[w] !== ea || wr_data_q[w] !== pack_word(b, w)) begin
                        failures++;
                        $display("FAIL load_word it=%0d w=%0d got %h@%h required %h@%h",
                                 it, w, wr_data_q[w], wr_addr_q[w], pack_word(b, w), ea);
                    end
                end
            end
`ifdef UART_MEM_CHKSUM_EN
            checks++;
            if (chk_err !== 1'b0) begin
                failures++;
                $display("FAIL load_chk_err it=%0d got %b required 0", it, chk_err);
            end
`endif
        end
    endtask

    task automatic test_dump;
        logic [DW-1:0] words [$];
        logic [7:0] eb [$];
        logic [AW-1:0] base;
        int wc, n;
        for (int it = 0; it < 4; it++) begin
            words.delete(); eb.delete();
            if (it == 0) begin
                base = 32'h200; wc = 1; words.push_back(32'hDEADBEEF);
            end else begin
                base = $urandom; wc = $urandom_range(0, 7);
                for (int i = 0; i < eff(wc); i++) words.push_back(DW'($urandom));
            end
            n = eff(wc);
            foreach (words[i]) begin
                mem_m[base + AW'(i*NB)] = words[i];
                for (int k = 0; k < NB; k++) eb.push_back(word_byte(words[i], k));
            end
            if (CHK != 0) eb.push_back(sum_bytes(eb));
            tx_q.delete(); tx_viol = 0; wr_addr_q.delete();
            do_start(1'b0, 1'b1, base, wc);
            send_byte(8'h55, 0);    // must be ignored during a dump
            send_byte(8'h66, 0);
            wait_done(1'b1, 3000);
            checks++;
            if (dump_done !== 1'b1 || busy !== 1'b0 || load_done !== 1'b0) begin
                failures++;
                $display("FAIL dump_status it=%0d got dd=%b busy=%b ld=%b required 1 0 0",
                         it, dump_done, busy, load_done);
            end
            checks++;
            if (tx_q.size() != eb.size() || tx_viol != 0 || wr_addr_q.size() != 0) begin
                failures++;
                $display("FAIL dump_stream it=%0d got %0d bytes viol=%0d writes=%0d required %0d 0 0",
                         it, tx_q.size(), tx_viol, wr_addr_q.size(), eb.size());
            end else begin
                foreach (eb[i]) begin
                    checks++;
                    if (tx_q[i] !== eb[i]) begin
                        failures++;
                        $display("FAIL dump_byte it=%0d i=%0d got %h required %h", it, i, tx_q[i], eb[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_timeout;
        bq_t b;
        logic [AW-1:0] base = $urandom;
        b = {8'h01, 8'h02, 8'h03, 8'h04};
        wr_addr_q.delete(); wr_data_q.delete();
        do_start(1'b1, 1'b0, base, 1);
        send_byte(8'hA1, RXT-3);
        checks++;
        if (err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early got %b required 0", err_timeout);
        end
        send_byte(8'hA2, RXT+5);
        checks++;
        if (err_timeout !== 1'b1 || wr_addr_q.size() != 0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_flag got to=%b writes=%0d busy=%b required 1 0 1",
                     err_timeout, wr_addr_q.size(), busy);
        end
        foreach (b[j]) send_byte(b[j], 0);
        if (CHK != 0) send_byte(8'h0A, 0);
        wait_done(1'b0, 200);
        checks++;
        if (load_done !== 1'b1 || err_timeout !== 1'b1 || wr_addr_q.size() != 1) begin
            failures++;
            $display("FAIL timeout_done got ld=%b to=%b writes=%0d required 1 1 1",
                     load_done, err_timeout, wr_addr_q.size());
        end else begin
            checks++;
            if (wr_addr_q[0] !== base || wr_data_q[0] !== pack_word(b, 0)) begin
                failures++;
                $display("FAIL timeout_word got %h@%h required %h@%h",
                         wr_data_q[0], wr_addr_q[0], pack_word(b, 0), base);
            end
        end
    endtask

    task automatic test_back_to_back;
        bq_t b;
        logic [AW-1:0] base = $urandom;
        for (int i = 0; i < NB; i++) b.push_back(8'($urandom));
        wr_addr_q.delete(); wr_data_q.delete(); tx_q.delete();
        @(negedge clk);
        start_load = 1'b1; start_dump = 1'b1; base_addr = base; word_count = CW'(1);
        @(negedge clk);
        start_load = 1'b0; start_dump = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL both_start_busy got %b required 1", busy);
        end
        start_dump = 1'b1; start_load = 1'b1; base_addr = base + 32'h40; word_count = CW'(3);
        @(negedge clk);
        start_dump = 1'b0; start_load = 1'b0;
        foreach (b[j]) send_byte(b[j], 0);
        if (CHK != 0) send_byte(sum_bytes(b), 0);
        wait_done(1'b0, 200);
        repeat (4) @(negedge clk);
        checks++;
        if (load_done !== 1'b1 || dump_done !== 1'b0 || busy !== 1'b0 || tx_q.size() != 0
            || wr_addr_q.size() != 1) begin
            failures++;
            $display("FAIL both_start_path got ld=%b dd=%b busy=%b tx=%0d writes=%0d required 1 0 0 0 1",
                     load_done, dump_done, busy, tx_q.size(), wr_addr_q.size());
        end else begin
            checks++;
            if (wr_addr_q[0] !== base || wr_data_q[0] !== pack_word(b, 0)) begin
                failures++;
                $display("FAIL both_start_word got %h@%h required %h@%h",
                         wr_data_q[0], wr_addr_q[0], pack_word(b, 0), base);
            end
        end
    endtask

    task automatic test_reset_mid;
        bq_t b;
        logic [AW-1:0] base = $urandom;
        wr_addr_q.delete(); wr_data_q.delete();
        do_start(1'b1, 1'b0, base, 2);
        for (int j = 0; j < 3; j++) send_byte(8'($urandom), 0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, load_done, dump_done, err_timeout, mem_we, tx_dv} !== 6'b0 || mem_addr !== '0
            || mem_wdata !== '0 || tx_byte !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got busy=%b ld=%b we=%b addr=%h", busy, load_done, mem_we, mem_addr);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_nowrite got writes=%0d busy=%b required 0 0", wr_addr_q.size(), busy);
        end
        for (int i = 0; i < NB; i++) b.push_back(8'($urandom));
        do_start(1'b1, 1'b0, base, 1);
        foreach (b[j]) send_byte(b[j], 1);
        if (CHK != 0) send_byte(sum_bytes(b), 0);
        wait_done(1'b0, 200);
        checks++;
        if (load_done !== 1'b1 || wr_addr_q.size() != 1) begin
            failures++;
            $display("FAIL reset_mid_reload got ld=%b writes=%0d required 1 1", load_done, wr_addr_q.size());
        end else begin
            checks++;
            if (wr_addr_q[0] !== base || wr_data_q[0] !== pack_word(b, 0)) begin
                failures++;
                $display("FAIL reset_mid_word got %h@%h required %h@%h",
                         wr_data_q[0], wr_addr_q[0], pack_word(b, 0), base);
            end
        end
    endtask

`ifdef UART_MEM_CHKSUM_EN
    task automatic test_chksum;
        bq_t b;
        b = {8'h01, 8'h02, 8'h03, 8'h04};
        for (int it = 0; it < 2; it++) begin
            do_start(1'b1, 1'b0, 32'h300, 1);
            foreach (b[j]) send_byte(b[j], 0);
            send_byte((it == 0) ? 8'h0A : 8'h0B, 0);
            wait_done(1'b0, 200);
            checks++;
            if (load_done !== 1'b1 || chk_err !== (it == 1)) begin
                failures++;
                $display("FAIL chksum it=%0d got ld=%b chk_err=%b required 1 %0d", it, load_done, chk_err, it);
            end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_load;
        test_dump;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
`ifdef UART_MEM_CHKSUM_EN
        test_chksum;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_mem_xfer.md
Name: uart_mem_xfer

Overview:
- Parametrised UART-to-memory loader and memory-to-UART dumper; successor to the fixed 32-bit, fixed-size loader.
- Sits between the uart_rx/uart_tx byte engines (instantiated at top level) and a single-port instruction/data memory.
- Configurable word width, depth, transfer length, read latency and byte order.
- Explicit load/dump commands, busy/done/error status, and a mid-word receive timeout.

Parameters:
- DATA_W, 32, memory word width in bits; must be a multiple of 8, range 8..64.
- ADDR_W, 32, memory address width (byte address).
- DEPTH, 256, maximum words per transfer.
- RD_LAT, 1, memory read latency in cycles (1..4).
- MSB_FIRST, 1, 1 = first UART byte is word MSB; 0 = LSB first. Applies to both load and dump.
- RX_TIMEOUT, 100000, idle clk cycles allowed between bytes of a partial word.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_load  in  1  single-cycle pulse; begin UART-to-memory load
- start_dump  in  1  single-cycle pulse; begin memory-to-UART dump
- base_addr  in  ADDR_W  byte address of word 0; sampled on start
- word_count  in  clog2(DEPTH)+1  words to transfer; 0 or >DEPTH means DEPTH; sampled on start
- rx_dv  in  1  one-cycle strobe, rx_byte valid
- rx_byte  in  8  received byte
- tx_dv  out  1  one-cycle strobe to uart_tx
- tx_byte  out  8  byte to send
- tx_active  in  1  uart_tx busy
- tx_done  in  1  uart_tx byte-complete pulse
- mem_addr  out  ADDR_W  byte address; advances by DATA_W/8 per word
- mem_we  out  1  write enable, one-cycle pulse per word
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after mem_addr
- busy  out  1  transfer in progress
- load_done  out  1  sticky; set at end of load, cleared on next start
- dump_done  out  1  sticky; set at end of dump, cleared on next start
- err_timeout  out  1  sticky; partial word discarded, cleared on next start

Behaviour:
- Reset: every output 0, FSM in IDLE, internal counters 0.
- Reset takes priority at any point; an in-flight transfer is abandoned with no further mem_we or tx_dv.
- States: IDLE, LOAD, LOAD_WR, DUMP_RD, DUMP_WAIT, DUMP_TX, DUMP_ACK.
- IDLE:
  - start_load -> LOAD; start_dump -> DUMP_RD.
  - Both asserted in the same cycle: load wins.
  - On either start: clear all sticky status, latch base_addr and the effective count, set busy next cycle.
  - Starts are ignored while busy.
- LOAD:
  - Each rx_dv shifts rx_byte into the word assembler at the position set by MSB_FIRST.
  - The byte counter and timeout counter reset on every rx_dv.
  - On the last byte (DATA_W/8 th), go to LOAD_WR.
  - LOAD_WR lasts one cycle: mem_we=1, mem_wdata = assembled word, mem_addr = base + idx*(DATA_W/8).
  - A write occurs 1 cycle after the final byte's rx_dv.
  - After the write, idx increments. If idx reaches the count: load_done=1, busy=0, return to IDLE. Otherwise return to LOAD.
  - Timeout: byte counter nonzero and RX_TIMEOUT cycles with no rx_dv -> discard the partial word, byte counter=0, err_timeout=1. idx is not advanced and the load continues.
  - rx_dv arriving in LOAD_WR is accepted as byte 0 of the next word; no byte is lost.
- Dump:
  - DUMP_RD drives mem_addr, then DUMP_WAIT holds for RD_LAT cycles and latches mem_rdata.
  - DUMP_TX issues tx_dv (1 cycle) with the selected byte, only when tx_active=0.
  - DUMP_ACK waits for tx_done, then moves to the next byte, or to the next word via DUMP_RD.
  - After the final byte's tx_done: dump_done=1, busy=0, return to IDLE.
  - rx_dv is ignored during a dump.
- mem_we is never asserted outside LOAD_WR.
- Address arithmetic wraps modulo 2^ADDR_W.
- Byte count of a transfer is exactly count*(DATA_W/8), plus the checksum byte when enabled.

Optional Feature:
- Macro UART_MEM_CHKSUM_EN.
- Defined, load: one extra trailing byte is expected after the last word. It is compared with the 8-bit modulo-256 sum of all data bytes. A mismatch sets sticky output chk_err (port exists only when defined). load_done is set after the checksum byte.
- Defined, dump: the 8-bit sum of all sent bytes is appended as a final byte before dump_done.
- Undefined: no checksum byte, no chk_err port, behaviour exactly as above.

Test Plan:
- DATA_W=32, MSB_FIRST=1, base=0x100, count=2; rx bytes 12 34 56 78 AA BB CC DD -> mem_we at 0x100 with 0x12345678 and at 0x104 with 0xAABBCCDD; load_done=1; busy=0.
- Dump count=1, memory word 0xDEADBEEF, MSB_FIRST=0 -> tx_byte sequence EF BE AD DE, each tx_dv only after the prior tx_done; then dump_done=1.
- Send 2 bytes, idle RX_TIMEOUT cycles, then 4 bytes 01 02 03 04 -> err_timeout=1; single write of 0x01020304 at base.
- start_load and start_dump in the same cycle -> load path taken; further starts while busy produce no effect.
- rst asserted after byte 3 of a word -> no mem_we; all outputs 0; a new load starts cleanly at byte 0.
- UART_MEM_CHKSUM_EN, DATA_W=16, bytes 01 02 03 04 plus checksum 0x0A -> chk_err=0; with checksum 0x0B -> chk_err=1.
